y86_decode_execute_ctl: RTL and testbench



---
 rtl/y86_decode_execute_ctl.sv | 256 +++++++++++++++++++++++++
 tb/tb_y86_decode_execute_ctl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_decode_execute_ctl.sv
// rtl/y86_decode_execute_ctl.sv - Y86-64 decode/execute stage with register file, CC and hazard control
module y86_decode_execute_ctl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic [2:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valC,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    output logic [2:0]  d_stat,
    output logic [3:0]  d_icode,
    output logic [3:0]  d_ifun,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM,
    output logic [63:0] d_valA,
    output logic [63:0] d_valB,
    output logic [63:0] d_valC,
    output logic [2:0]  e_stat,
    output logic [3:0]  e_icode,
    output logic        e_Cnd,
    output logic [63:0] e_valE,
    output logic [63:0] e_valA,
    output logic [3:0]  e_dstE,
    output logic [3:0]  e_dstM,
    output logic        ZF,
    output logic        SF,
    output logic        OF,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic [63:0] reg_file0,
    output logic [63:0] reg_file1,
    output logic [63:0] reg_file2,
    output logic [63:0] reg_file3,
    output logic [63:0] reg_file4,
    output logic [63:0] reg_file5,
    output logic [63:0] reg_file6,
    output logic [63:0] reg_file7,
    output logic [63:0] reg_file8,
    output logic [63:0] reg_file9,
    output logic [63:0] reg_file10,
    output logic [63:0] reg_file11,
    output logic [63:0] reg_file12,
    output logic [63:0] reg_file13,
    output logic [63:0] reg_file14
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [63:0] reg_q [0:14];
    logic [63:0] reg_d [0:14];
    logic        zf_q, sf_q, of_q, zf_d, sf_d, of_d;
    logic [63:0] alu_a, alu_b;
    logic        alu_of, loaduse, ret_in_flight, mispred;

    function automatic logic exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic logic [63:0] rf_read(input logic [3:0] src);
        return (src == RNONE) ? 64'd0 : reg_q[src];
    endfunction

    // First matching stage wins; the youngest producer is checked first.
    function automatic logic [63:0] fwd_sel(
        input logic [3:0] src,   input logic [63:0] rf_val,
        input logic [3:0] e_dst, input logic [63:0] e_val,
        input logic [3:0] mm_d,  input logic [63:0] mm_v,
        input logic [3:0] me_d,  input logic [63:0] me_v,
        input logic [3:0] wm_d,  input logic [63:0] wm_v,
        input logic [3:0] we_d,  input logic [63:0] we_v);
        if (src == RNONE)     return 64'd0;
        else if (src == e_dst) return e_val;
        else if (src == mm_d)  return mm_v;
        else if (src == me_d)  return me_v;
        else if (src == wm_d)  return wm_v;
        else if (src == we_d)  return we_v;
        else                   return rf_val;
    endfunction

    assign d_stat  = D_stat;
    assign d_icode = D_icode;
    assign d_ifun  = D_ifun;
    assign d_valC  = D_valC;

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            4'h2, 4'h4, 4'h6, 4'hA: d_srcA = D_rA;
            4'h9, 4'hB:             d_srcA = RSP;
            default:                d_srcA = RNONE;
        endcase
        case (D_icode)
            4'h4, 4'h5, 4'h6:       d_srcB = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: d_srcB = RSP;
            default:                d_srcB = RNONE;
        endcase
        case (D_icode)
            4'h2, 4'h3, 4'h6:       d_dstE = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: d_dstE = RSP;
            default:                d_dstE = RNONE;
        endcase
        if (D_icode == 4'h5 || D_icode == 4'hB) d_dstM = D_rA;
    end

    always_comb begin
        if (D_icode == 4'h7 || D_icode == 4'h8)
            d_valA = D_valP;
        else
            d_valA = fwd_sel(d_srcA, rf_read(d_srcA), e_dstE, e_valE, M_dstM, m_valM,
                             M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
        d_valB = fwd_sel(d_srcB, rf_read(d_srcB), e_dstE, e_valE, M_dstM, m_valM,
                         M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    end

    always_comb begin
        alu_a  = 64'd0;
        alu_b  = 64'd0;
        alu_of = 1'b0;
        case (E_icode)
            4'h2, 4'h6:       alu_a = E_valA;
            4'h3, 4'h4, 4'h5: alu_a = E_valC;
            4'h8, 4'hA:       alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            4'h9, 4'hB:       alu_a = 64'd8;
            default:          alu_a = 64'd0;
        endcase
        case (E_icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = E_valB;
            default:                                  alu_b = 64'd0;
        endcase
        case ((E_icode == 4'h6) ? E_ifun : 4'h0)
            4'h1: begin
                e_valE = alu_b - alu_a;
                alu_of = (alu_a[63] != alu_b[63]) && (e_valE[63] != alu_b[63]);
            end
            4'h2: e_valE = alu_b & alu_a;
            4'h3: e_valE = alu_b ^ alu_a;
            default: begin
                e_valE = alu_b + alu_a;
                alu_of = (alu_a[63] == alu_b[63]) && (e_valE[63] != alu_a[63]);
            end
        endcase
    end

    always_comb begin
        case (E_ifun)
            4'h0:    e_Cnd = 1'b1;
            4'h1:    e_Cnd = (sf_q ^ of_q) | zf_q;
            4'h2:    e_Cnd = sf_q ^ of_q;
            4'h3:    e_Cnd = zf_q;
            4'h4:    e_Cnd = ~zf_q;
            4'h5:    e_Cnd = ~(sf_q ^ of_q);
            4'h6:    e_Cnd = ~(sf_q ^ of_q) & ~zf_q;
            default: e_Cnd = 1'b0;
        endcase
    end

    assign e_dstE  = (E_icode == 4'h2 && !e_Cnd) ? RNONE : E_dstE;
    assign e_valA  = E_valA;
    assign e_stat  = E_stat;
    assign e_icode = E_icode;
    assign e_dstM  = E_dstM;

    // CC is frozen once an exception is visible downstream so it reflects the faulting point.
    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (E_icode == 4'h6 && !exc(m_stat) && !exc(W_stat)) begin
            zf_d = (e_valE == 64'd0);
            sf_d = e_valE[63];
            of_d = alu_of;
        end
    end

    always_comb begin
        for (int i = 0; i < 15; i++) reg_d[i] = reg_q[i];
        if (W_dstE != RNONE) reg_d[W_dstE] = W_valE;
        if (W_dstM != RNONE) reg_d[W_dstM] = W_valM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) reg_q[i] <= 64'd0;
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            for (int i = 0; i < 15; i++) reg_q[i] <= reg_d[i];
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    assign ZF = zf_q;
    assign SF = sf_q;
    assign OF = of_q;

    assign loaduse       = (E_icode == 4'h5 || E_icode == 4'hB) &&
                           (E_dstM == d_srcA || E_dstM == d_srcB);
    assign ret_in_flight = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    assign mispred       = (E_icode == 4'h7) && !e_Cnd;

    assign F_stall  = loaduse | ret_in_flight;
    assign D_stall  = loaduse;
    assign D_bubble = mispred | (ret_in_flight & ~loaduse);
    assign E_bubble = mispred | loaduse;
    assign M_bubble = exc(m_stat) | exc(W_stat);
    assign W_stall  = exc(W_stat);

    assign reg_file0  = reg_q[0];
    assign reg_file1  = reg_q[1];
    assign reg_file2  = reg_q[2];
    assign reg_file3  = reg_q[3];
    assign reg_file4  = reg_q[4];
    assign reg_file5  = reg_q[5];
    assign reg_file6  = reg_q[6];
    assign reg_file7  = reg_q[7];
    assign reg_file8  = reg_q[8];
    assign reg_file9  = reg_q[9];
    assign reg_file10 = reg_q[10];
    assign reg_file11 = reg_q[11];
    assign reg_file12 = reg_q[12];
    assign reg_file13 = reg_q[13];
    assign reg_file14 = reg_q[14];
endmodule

// File: tb/tb_y86_decode_execute_ctl.sv
// tb/tb_y86_decode_execute_ctl.sv - randomized bench with behavioural model for y86_decode_execute_ctl
module tb_y86_decode_execute_ctl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  D_stat, E_stat, m_stat, W_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB, E_icode, E_ifun, E_dstE, E_dstM;
    logic [3:0]  M_icode, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] D_valC, D_valP, E_valC, E_valA, E_valB, M_valE, m_valM, W_valE, W_valM;
    logic [2:0]  d_stat, e_stat;
    logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM, e_icode, e_dstE, e_dstM;
    logic [63:0] d_valA, d_valB, d_valC, e_valE, e_valA;
    logic        e_Cnd, ZF, SF, OF, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [63:0] rfo [15];

    y86_decode_execute_ctl dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
        .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE),
        .m_valM(m_valM), .m_stat(m_stat),
        .W_stat(W_stat), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
        .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE), .e_valA(e_valA),
        .e_dstE(e_dstE), .e_dstM(e_dstM),
        .ZF(ZF), .SF(SF), .OF(OF),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall),
        .reg_file0(rfo[0]), .reg_file1(rfo[1]), .reg_file2(rfo[2]), .reg_file3(rfo[3]),
        .reg_file4(rfo[4]), .reg_file5(rfo[5]), .reg_file6(rfo[6]), .reg_file7(rfo[7]),
        .reg_file8(rfo[8]), .reg_file9(rfo[9]), .reg_file10(rfo[10]), .reg_file11(rfo[11]),
        .reg_file12(rfo[12]), .reg_file13(rfo[13]), .reg_file14(rfo[14])
    );

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;
    logic [63:0] mrf [15];
    logic mzf, msf, mof;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mrf[i] = 64'd0;
        mzf = 1'b1; msf = 1'b0; mof = 1'b0;
    endtask

    function automatic bit is_exc(input logic [2:0] s);
        return s inside {3'd2, 3'd3, 3'd4};
    endfunction

    // Returns {overflow, result}; overflow = the true signed result does not fit in 64 bits.
    function automatic logic [64:0] model_alu(input logic [3:0] ic, input logic [3:0] fn,
                                              input logic [63:0] va, input logic [63:0] vb,
                                              input logic [63:0] vc);
        logic [63:0] a, b;
        logic [64:0] w;
        a = 64'd0; b = 64'd0;
        if (ic inside {4'h2, 4'h6})            a = va;
        else if (ic inside {4'h3, 4'h4, 4'h5}) a = vc;
        else if (ic inside {4'h8, 4'hA})       a = -64'd8;
        else if (ic inside {4'h9, 4'hB})       a = 64'd8;
        if (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) b = vb;
        if (ic == 4'h6 && fn == 4'h1) begin
            w = {b[63], b} - {a[63], a};
            return {w[64] != w[63], w[63:0]};
        end
        if (ic == 4'h6 && fn == 4'h2) return {1'b0, a & b};
        if (ic == 4'h6 && fn == 4'h3) return {1'b0, a ^ b};
        w = {a[63], a} + {b[63], b};
        return {w[64] != w[63], w[63:0]};
    endfunction

    function automatic bit model_cnd(input logic [3:0] fn, input bit z, input bit s, input bit o);
        bit lt;
        lt = s ^ o;
        case (fn)
            4'd0: return 1'b1;
            4'd1: return lt || z;
            4'd2: return lt;
            4'd3: return z;
            4'd4: return !z;
            4'd5: return !lt;
            4'd6: return !lt && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] model_fwd(input logic [3:0] src, input logic [3:0] edst,
                                              input logic [63:0] evl);
        logic [3:0]  dsts [5];
        logic [63:0] vals [5];
        if (src == 4'hF) return 64'd0;
        dsts = '{edst, M_dstM, M_dstE, W_dstM, W_dstE};
        vals = '{evl, m_valM, M_valE, W_valM, W_valE};
        for (int k = 0; k < 5; k++) if (dsts[k] == src) return vals[k];
        return mrf[src];
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            logic [64:0] r;
            r = model_alu(E_icode, E_ifun, E_valA, E_valB, E_valC);
            if (W_dstE != 4'hF) mrf[W_dstE] = W_valE;
            if (W_dstM != 4'hF) mrf[W_dstM] = W_valM;
            if (E_icode == 4'h6 && !is_exc(m_stat) && !is_exc(W_stat)) begin
                mzf = (r[63:0] == 64'd0);
                msf = r[63];
                mof = r[64];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            logic [64:0] r;
            bit cnd, lu, rt, mp;
            logic [3:0] xdst, sa, sb, de, dm;
            r    = model_alu(E_icode, E_ifun, E_valA, E_valB, E_valC);
            cnd  = model_cnd(E_ifun, mzf, msf, mof);
            xdst = (E_icode == 4'h2 && !cnd) ? 4'hF : E_dstE;
            sa = (D_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? D_rA :
                 (D_icode inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
            sb = (D_icode inside {4'h4, 4'h5, 4'h6}) ? D_rB :
                 (D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
            de = (D_icode inside {4'h2, 4'h3, 4'h6}) ? D_rB :
                 (D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
            dm = (D_icode inside {4'h5, 4'hB}) ? D_rA : 4'hF;
            lu = (E_icode inside {4'h5, 4'hB}) && (E_dstM == sa || E_dstM == sb);
            rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
            mp = (E_icode == 4'h7) && !cnd;
            chk("d_stat", d_stat, D_stat);
            chk("d_icode", d_icode, D_icode);
            chk("d_ifun", d_ifun, D_ifun);
            chk("d_valC", d_valC, D_valC);
            chk("d_srcA", d_srcA, sa);
            chk("d_srcB", d_srcB, sb);
            chk("d_dstE", d_dstE, de);
            chk("d_dstM", d_dstM, dm);
            chk("d_valA", d_valA, (D_icode inside {4'h7, 4'h8}) ? D_valP : model_fwd(sa, xdst, r[63:0]));
            chk("d_valB", d_valB, model_fwd(sb, xdst, r[63:0]));
            if (E_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB})
                chk("e_valE", e_valE, r[63:0]);
            chk("e_Cnd", e_Cnd, cnd);
            chk("e_dstE", e_dstE, xdst);
            chk("e_valA", e_valA, E_valA);
            chk("e_stat", e_stat, E_stat);
            chk("e_icode", e_icode, E_icode);
            chk("e_dstM", e_dstM, E_dstM);
            chk("cc", {ZF, SF, OF}, {mzf, msf, mof});
            chk("F_stall", F_stall, lu || rt);
            chk("D_stall", D_stall, lu);
            chk("D_bubble", D_bubble, mp || (rt && !lu));
            chk("E_bubble", E_bubble, mp || lu);
            chk("M_bubble", M_bubble, is_exc(m_stat) || is_exc(W_stat));
            chk("W_stall", W_stall, is_exc(W_stat));
            for (int i = 0; i < 15; i++) chk($sformatf("reg_file%0d", i), rfo[i], mrf[i]);
        end
    end

    task automatic idle();
        D_stat = 3'd1; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = 64'd0; D_valP = 64'd0;
        E_stat = 3'd1; E_icode = 4'h1; E_ifun = 4'h0; E_valC = 64'd0; E_valA = 64'd0;
        E_valB = 64'd0; E_dstE = 4'hF; E_dstM = 4'hF;
        M_icode = 4'h1; M_dstE = 4'hF; M_dstM = 4'hF; M_valE = 64'd0;
        m_valM = 64'd0; m_stat = 3'd1;
        W_stat = 3'd1; W_dstE = 4'hF; W_dstM = 4'hF; W_valE = 64'd0; W_valM = 64'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rval();
        if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 3));
        return {$urandom, $urandom};
    endfunction

    function automatic logic [2:0] rstat();
        if ($urandom_range(0, 3) == 0) return 3'($urandom_range(0, 7));
        return 3'd1;
    endfunction

    task automatic randomize_inputs();
        D_stat = rstat(); D_icode = 4'($urandom_range(0, 15)); D_ifun = 4'($urandom_range(0, 15));
        D_rA = 4'($urandom_range(0, 15)); D_rB = 4'($urandom_range(0, 15));
        D_valC = rval(); D_valP = rval();
        E_stat = rstat(); E_icode = 4'($urandom_range(0, 11));
        E_ifun = (E_icode == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        E_valC = rval(); E_valA = rval();
        E_valB = ($urandom_range(0, 7) == 0) ? E_valA : rval();
        E_dstE = (E_icode inside {4'h0, 4'h1, 4'h7}) ? 4'hF : 4'($urandom_range(0, 15));
        E_dstM = 4'($urandom_range(0, 15));
        M_icode = 4'($urandom_range(0, 11)); M_dstE = 4'($urandom_range(0, 15));
        M_dstM = 4'($urandom_range(0, 15)); M_valE = rval();
        m_valM = rval(); m_stat = rstat();
        W_stat = rstat(); W_dstE = 4'($urandom_range(0, 15)); W_dstM = 4'($urandom_range(0, 15));
        W_valE = rval(); W_valM = rval();
    endtask

    initial begin
        model_reset();
        idle();
        #12;
        for (int i = 0; i < 15; i++) chk("reset_rf", rfo[i], 64'd0);
        chk("reset_cc", {ZF, SF, OF}, 3'b100);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        step();
        W_dstE = 4'd3; W_valE = 64'd10;
        step();
        W_dstE = 4'hF; D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'hF;
        #1;
        chk("wr_rd_valA", d_valA, 64'd10);
        chk("wr_rd_rf3", rfo[3], 64'd10);

        step();
        idle();
        E_icode = 4'h2; E_ifun = 4'h0; E_dstE = 4'd2; E_valA = 64'd5;
        M_dstE = 4'd2; M_valE = 64'd7; D_icode = 4'h2; D_rA = 4'd2;
        #1;
        chk("fwd_e_first", d_valA, 64'd5);
        E_dstE = 4'hF;
        #1;
        chk("fwd_m_next", d_valA, 64'd7);

        step();
        idle();
        E_icode = 4'h6; E_ifun = 4'h1; E_valA = 64'd1; E_valB = 64'h8000_0000_0000_0000;
        #1;
        chk("sub_valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        step();
        chk("sub_cc", {ZF, SF, OF}, 3'b001);
        W_stat = 3'd3; E_valB = 64'd1;
        #1;
        chk("exc_M_bubble", M_bubble, 1'b1);
        chk("exc_W_stall", W_stall, 1'b1);
        step();
        chk("cc_frozen", {ZF, SF, OF}, 3'b001);

        idle();
        E_icode = 4'h5; E_dstM = 4'd1; D_icode = 4'h6; D_rA = 4'd1;
        #1;
        chk("lu_ctl", {F_stall, D_stall, E_bubble, D_bubble}, 4'b1110);

        step();
        idle();
        E_icode = 4'h7; E_ifun = 4'h3;
        #1;
        chk("mp_ctl", {e_Cnd, D_bubble, E_bubble}, 3'b011);
        E_icode = 4'h2; E_dstE = 4'd5;
        #1;
        chk("cmov_dstE", e_dstE, 4'hF);

        repeat (3000) begin
            step();
            randomize_inputs();
        end

        step();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) chk("async_rst_rf", rfo[i], 64'd0);
        chk("async_rst_ZF", ZF, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        repeat (300) begin
            step();
            randomize_inputs();
        end
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
